// File: rtl/pcie_cfg_pkg.sv
// Shared definitions for the PCIe configuration space block: APB FSM
// states, configuration register offsets, command/status bit positions
// and a byte-lane merge helper.
package pcie_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    WAIT   = 2'd2,
    ACCESS = 2'd3
  } apb_state_t;

  // Type-0 header offsets (byte addresses, dword aligned)
  localparam logic [11:0] OFF_ID      = 12'h000;
  localparam logic [11:0] OFF_CMD_STS = 12'h004;
  localparam logic [11:0] OFF_CLASS   = 12'h008;
  localparam logic [11:0] OFF_HDR     = 12'h00C;
  localparam logic [11:0] OFF_BAR0    = 12'h010;
  localparam logic [11:0] OFF_SUBSYS  = 12'h02C;
  localparam logic [11:0] OFF_EXP_ROM = 12'h030;
  localparam logic [11:0] OFF_INT     = 12'h03C;
  localparam logic [11:0] OFF_SCRATCH = 12'h040;
  localparam logic [11:0] OFF_MAX     = 12'h040;

  localparam int unsigned MAX_BAR = 6;

  // Command register bit positions
  localparam int unsigned CMD_IO_EN      = 0;
  localparam int unsigned CMD_MEM_EN     = 1;
  localparam int unsigned CMD_BUS_MASTER = 2;
  localparam int unsigned CMD_INTX_DIS   = 10;

  // Status register bit position (within the 16-bit status half)
  localparam int unsigned STS_ERR = 11;

  // Replace the bytes of old_val selected by strb with those of wdata
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int unsigned k = 0; k < 4; k++) begin
      if (strb[k]) r[8*k +: 8] = wdata[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/pcie_cfg_func.sv
// One PCIe function's configuration registers: command/status with the
// RW1C error flag, size-masked memory BARs and the writable header fields.
module pcie_cfg_func #(
  parameter int unsigned NUM_FUNC          = 2,
  parameter int unsigned NUM_BAR           = 2,
  parameter int unsigned BAR_APERTURE_LOG2 = 12,
  parameter logic [15:0] VENDOR_ID         = 16'h144D,
  parameter logic [15:0] DEVICE_ID         = 16'hA800,
  parameter logic [23:0] CLASS_CODE        = 24'h010802,
  parameter logic [7:0]  REV_ID            = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [11:0] offset,
  input  logic [31:0] wdata,
  input  logic [3:0]  strb,
  input  logic        err_event,
  output logic [31:0] rd_data,
  output logic        mem_en,
  output logic        bus_master
);
  import pcie_cfg_pkg::*;

  localparam logic [7:0]  HEADER_TYPE = (NUM_FUNC > 1) ? 8'h80 : 8'h00;
  localparam logic [31:0] BAR_MASK    = ~((32'd1 << BAR_APERTURE_LOG2) - 32'd1);

  logic [2:0]  cmd_q;
  logic        intx_dis_q;
  logic        sts_err_q;
  logic [7:0]  cls_q;
  logic [7:0]  lat_q;
  logic [31:0] bar_q [MAX_BAR];
  logic [31:0] subsys_q;
  logic [31:0] rom_q;
  logic [31:0] int_q;
  logic [31:0] scratch_q;
  logic        w1c_err;

  assign w1c_err    = wr_en && (offset == OFF_CMD_STS) && strb[3] && wdata[16 + STS_ERR];
  assign mem_en     = cmd_q[CMD_MEM_EN];
  assign bus_master = cmd_q[CMD_BUS_MASTER];

  // Register writes; the error flag is set by err_event, which beats a clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q      <= '0;
      intx_dis_q <= 1'b0;
      sts_err_q  <= 1'b0;
      cls_q      <= '0;
      lat_q      <= '0;
      subsys_q   <= '0;
      rom_q      <= '0;
      int_q      <= '0;
      scratch_q  <= '0;
      for (int unsigned n = 0; n < MAX_BAR; n++) bar_q[n] <= '0;
    end else begin
      sts_err_q <= err_event | (sts_err_q & ~w1c_err);
      if (wr_en) begin
        case (offset)
          OFF_CMD_STS: begin
            if (strb[0]) cmd_q <= wdata[CMD_BUS_MASTER:CMD_IO_EN];
            if (strb[1]) intx_dis_q <= wdata[CMD_INTX_DIS];
          end
          OFF_HDR: begin
            if (strb[0]) cls_q <= wdata[7:0];
            if (strb[1]) lat_q <= wdata[15:8];
          end
          OFF_SUBSYS:  subsys_q  <= merge_bytes(subsys_q, wdata, strb);
          OFF_EXP_ROM: rom_q     <= merge_bytes(rom_q, wdata, strb);
          OFF_INT:     int_q     <= merge_bytes(int_q, wdata, strb);
          OFF_SCRATCH: scratch_q <= merge_bytes(scratch_q, wdata, strb);
          default: ;
        endcase
        for (int unsigned n = 0; n < MAX_BAR; n++) begin
          if ((n < NUM_BAR) && (offset == OFF_BAR0 + 12'(4 * n)))
            bar_q[n] <= merge_bytes(bar_q[n], wdata, strb) & BAR_MASK;
        end
      end
    end
  end

  // Read decode for this function; unimplemented offsets return zero
  always_comb begin
    rd_data = '0;
    case (offset)
      OFF_ID:      rd_data = {DEVICE_ID, VENDOR_ID};
      OFF_CMD_STS: begin
        rd_data[CMD_BUS_MASTER:CMD_IO_EN] = cmd_q;
        rd_data[CMD_INTX_DIS]             = intx_dis_q;
        rd_data[16 + STS_ERR]             = sts_err_q;
      end
      OFF_CLASS:   rd_data = {CLASS_CODE, REV_ID};
      OFF_HDR:     rd_data = {8'h00, HEADER_TYPE, lat_q, cls_q};
      OFF_SUBSYS:  rd_data = subsys_q;
      OFF_EXP_ROM: rd_data = rom_q;
      OFF_INT:     rd_data = int_q;
      OFF_SCRATCH: rd_data = scratch_q;
      default: ;
    endcase
    for (int unsigned n = 0; n < MAX_BAR; n++) begin
      if ((n < NUM_BAR) && (offset == OFF_BAR0 + 12'(4 * n))) rd_data = bar_q[n];
    end
  end

endmodule

// File: rtl/pcie_cfg_space.sv
// APB-attached PCIe configuration space: APB FSM with configurable wait
// states, address decode and error check, and the cross-function read mux.
module pcie_cfg_space #(
  parameter int unsigned NUM_FUNC          = 2,
  parameter int unsigned NUM_BAR           = 2,
  parameter int unsigned BAR_APERTURE_LOG2 = 12,
  parameter int unsigned WAIT_STATES       = 1,
  parameter logic [15:0] VENDOR_ID         = 16'h144D,
  parameter logic [15:0] DEVICE_ID         = 16'hA800,
  parameter logic [23:0] CLASS_CODE        = 24'h010802,
  parameter logic [7:0]  REV_ID            = 8'h01
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [14:0]         paddr_i,
  input  logic [31:0]         pwdata_i,
  input  logic [3:0]          pstrb_i,
  output logic                pready_o,
  output logic [31:0]         prdata_o,
  output logic                pslverr_o,
  input  logic [NUM_FUNC-1:0] func_err_i,
  output logic [NUM_FUNC-1:0] mem_en_o,
  output logic [NUM_FUNC-1:0] bus_master_o
);
  import pcie_cfg_pkg::*;

  localparam logic [1:0] WS = 2'(WAIT_STATES);

  apb_state_t  state;
  logic [1:0]  wait_cnt;
  logic [2:0]  fn_q;
  logic [11:0] off_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic        write_q;
  logic        acc_err;
  logic [31:0] rd_sel;
  logic [31:0] func_rd [NUM_FUNC];
  logic [NUM_FUNC-1:0] wr_en;

  assign acc_err = (32'(fn_q) >= NUM_FUNC) || (off_q > OFF_MAX) || (off_q[1:0] != 2'b00);

  // Select the addressed function's read word
  always_comb begin
    rd_sel = '0;
    for (int unsigned f = 0; f < NUM_FUNC; f++) begin
      if (32'(fn_q) == f) rd_sel = func_rd[f];
    end
  end

  // APB FSM; bus fields are captured on entry to SETUP and the response
  // is registered on entry to ACCESS so it is valid for that whole cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      fn_q      <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      write_q   <= 1'b0;
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
      prdata_o  <= '0;
    end else begin
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
      prdata_o  <= '0;
      case (state)
        IDLE: begin
          if (psel_i && !penable_i) begin
            state   <= SETUP;
            fn_q    <= paddr_i[14:12];
            off_q   <= paddr_i[11:0];
            wdata_q <= pwdata_i;
            strb_q  <= pstrb_i;
            write_q <= pwrite_i;
          end
        end
        SETUP: begin
          if (WAIT_STATES > 0) begin
            state    <= WAIT;
            wait_cnt <= 2'd1;
          end else begin
            state     <= ACCESS;
            pready_o  <= 1'b1;
            pslverr_o <= acc_err;
            prdata_o  <= (!write_q && !acc_err) ? rd_sel : '0;
          end
        end
        WAIT: begin
          if (wait_cnt == WS) begin
            state     <= ACCESS;
            pready_o  <= 1'b1;
            pslverr_o <= acc_err;
            prdata_o  <= (!write_q && !acc_err) ? rd_sel : '0;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ACCESS: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // One register bank per function; writes land on the ACCESS cycle
  for (genvar f = 0; f < NUM_FUNC; f++) begin : g_func
    assign wr_en[f] = (state == ACCESS) && write_q && !acc_err && (fn_q == 3'(f));

    pcie_cfg_func #(
      .NUM_FUNC          (NUM_FUNC),
      .NUM_BAR           (NUM_BAR),
      .BAR_APERTURE_LOG2 (BAR_APERTURE_LOG2),
      .VENDOR_ID         (VENDOR_ID),
      .DEVICE_ID         (DEVICE_ID),
      .CLASS_CODE        (CLASS_CODE),
      .REV_ID            (REV_ID)
    ) u_func (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en[f]),
      .offset     (off_q),
      .wdata      (wdata_q),
      .strb       (strb_q),
      .err_event  (func_err_i[f]),
      .rd_data    (func_rd[f]),
      .mem_en     (mem_en_o[f]),
      .bus_master (bus_master_o[f])
    );
  end

endmodule

// File: tb/tb_pcie_cfg_space.sv
// Self-checking bench for pcie_cfg_space with a scoreboard of expected
// APB responses (3 wait states, 2 functions, 2 BARs of 4 KiB).
module tb_pcie_cfg_space;

  localparam int LAT = 5;  // 2 + WAIT_STATES

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [14:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [1:0]  func_err;
  logic [1:0]  mem_en, bus_master;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  pcie_cfg_space #(
    .NUM_FUNC          (2),
    .NUM_BAR           (2),
    .BAR_APERTURE_LOG2 (12),
    .WAIT_STATES       (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .psel_i       (psel),
    .penable_i    (penable),
    .pwrite_i     (pwrite),
    .paddr_i      (paddr),
    .pwdata_i     (pwdata),
    .pstrb_i      (pstrb),
    .pready_o     (pready),
    .prdata_o     (prdata),
    .pslverr_o    (pslverr),
    .func_err_i   (func_err),
    .mem_en_o     (mem_en),
    .bus_master_o (bus_master)
  );

  always #5 clk = ~clk;

  // One APB transfer; returns at the negedge inside the ACCESS cycle.
  // Bus fields are scrambled once the transfer is past SETUP.
  task automatic apb_xfer(input logic wr, input logic [2:0] fn, input logic [11:0] off,
                          input logic [31:0] wd, input logic [3:0] st,
                          output logic [31:0] rd, output logic er, output int cyc);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = {fn, off}; pwdata = wd; pstrb = st;
    @(negedge clk);
    cyc = 1;
    penable = 1'b1;
    while (!pready && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        pwdata = ~wd; pstrb = ~st; paddr = {fn ^ 3'd1, off ^ 12'h008}; pwrite = ~wr;
      end
    end
    vectors++;
    if (!pready) begin
      miscompares++;
      $display("FAIL pready_timeout: pready=%b after %0d cycles, want 1", pready, cyc);
    end
    rd = prdata; er = pslverr;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int cyc; exp_t e;
    logic [14:0] addr [5] = '{15'h0000, 15'h0004, 15'h0008, 15'h000C, 15'h1040};
    logic [31:0] want [5] = '{32'hA800_144D, 32'h0, 32'h0108_0201, 32'h0080_0000, 32'h0};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({pready, pslverr, prdata, mem_en, bus_master} !== 38'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b err=%b data=%h mem=%b bm=%b, want all 0",
               pready, pslverr, prdata, mem_en, bus_master);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(exp_t'{want[i], 1'b0});
      apb_xfer(1'b0, addr[i][14:12], addr[i][11:0], 32'h0, 4'h0, rd, er, cyc);
      e = sb.pop_front();
      vectors++;
      if (rd !== e.data || er !== e.err) begin
        miscompares++;
        $display("FAIL reset_read[%0d]: got %h/%b, want %h/%b", i, rd, er, e.data, e.err);
      end
    end
  endtask

  task automatic test_command();
    logic [31:0] rd; logic er; int cyc; exp_t e;
    sb.push_back(exp_t'{32'h0, 1'b0});
    apb_xfer(1'b1, 3'd0, 12'h004, 32'h0000_0006, 4'hF, rd, er, cyc);
    e = sb.pop_front();
    vectors++;
    if (rd !== e.data || er !== e.err || mem_en !== 2'b00) begin
      miscompares++;
      $display("FAIL cmd_write: got %h/%b mem=%b, want %h/%b mem=00", rd, er, mem_en, e.data, e.err);
    end
    @(negedge clk);
    vectors++;
    if (mem_en !== 2'b01 || bus_master !== 2'b01) begin
      miscompares++;
      $display("FAIL cmd_outputs: got mem=%b bm=%b, want 01/01", mem_en, bus_master);
    end
    sb.push_back(exp_t'{32'h0000_0006, 1'b0});
    apb_xfer(1'b0, 3'd0, 12'h004, 32'h0, 4'h0, rd, er, cyc);
    e = sb.pop_front();
    vectors++;
    if (rd !== e.data || er !== e.err) begin
      miscompares++;
      $display("FAIL cmd_read: got %h/%b, want %h/%b", rd, er, e.data, e.err);
    end
  endtask

  task automatic test_bar();
    logic [31:0] rd; logic er; int cyc; exp_t e;
    logic        wr   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  fn   [7] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    logic [11:0] off  [7] = '{12'h010, 12'h010, 12'h014, 12'h014, 12'h018, 12'h018, 12'h010};
    logic [31:0] wd   [7] = '{32'hFFFF_FFFF, 32'h0, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    logic [31:0] want [7] = '{32'h0, 32'hFFFF_F000, 32'h0, 32'h1234_5000, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 7; i++) begin
      sb.push_back(exp_t'{want[i], 1'b0});
      apb_xfer(wr[i], fn[i], off[i], wd[i], 4'hF, rd, er, cyc);
      e = sb.pop_front();
      vectors++;
      if (rd !== e.data || er !== e.err) begin
        miscompares++;
        $display("FAIL bar[%0d]: got %h/%b, want %h/%b", i, rd, er, e.data, e.err);
      end
    end
  endtask

  task automatic test_status();
    logic [31:0] rd; logic er; int cyc; exp_t e;
    @(negedge clk); func_err = 2'b01;
    @(negedge clk); func_err = 2'b00;
    sb.push_back(exp_t'{32'h0800_0006, 1'b0});
    apb_xfer(1'b0, 3'd0, 12'h004, 32'h0, 4'h0, rd, er, cyc);
    e = sb.pop_front();
    vectors++;
    if (rd !== e.data || er !== e.err) begin
      miscompares++;
      $display("FAIL sts_set: got %h/%b, want %h/%b", rd, er, e.data, e.err);
    end
    // W1C commits at the edge closing ACCESS, coinciding with this pulse
    apb_xfer(1'b1, 3'd0, 12'h004, 32'h0800_0006, 4'hF, rd, er, cyc);
    func_err = 2'b01;
    @(negedge clk); func_err = 2'b00;
    sb.push_back(exp_t'{32'h0800_0006, 1'b0});
    apb_xfer(1'b0, 3'd0, 12'h004, 32'h0, 4'h0, rd, er, cyc);
    e = sb.pop_front();
    vectors++;
    if (rd !== e.data || er !== e.err) begin
      miscompares++;
      $display("FAIL sts_set_wins: got %h/%b, want %h/%b", rd, er, e.data, e.err);
    end
    apb_xfer(1'b1, 3'd0, 12'h004, 32'h0800_0006, 4'hF, rd, er, cyc);
    sb.push_back(exp_t'{32'h0000_0006, 1'b0});
    apb_xfer(1'b0, 3'd0, 12'h004, 32'h0, 4'h0, rd, er, cyc);
    e = sb.pop_front();
    vectors++;
    if (rd !== e.data || er !== e.err) begin
      miscompares++;
      $display("FAIL sts_w1c: got %h/%b, want %h/%b", rd, er, e.data, e.err);
    end
    sb.push_back(exp_t'{32'h0, 1'b0});
    apb_xfer(1'b0, 3'd1, 12'h004, 32'h0, 4'h0, rd, er, cyc);
    e = sb.pop_front();
    vectors++;
    if (rd !== e.data || er !== e.err) begin
      miscompares++;
      $display("FAIL sts_f1_isolated: got %h/%b, want %h/%b", rd, er, e.data, e.err);
    end
  endtask

  task automatic test_scratch_timing();
    logic [31:0] rd; logic er; int cyc; exp_t e;
    logic        wr   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [11:0] off  [6] = '{12'h040, 12'h040, 12'h028, 12'h028, 12'h000, 12'h000};
    logic [31:0] wd   [6] = '{32'hAABB_CCDD, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0};
    logic [3:0]  st   [6] = '{4'b0101, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
    logic [31:0] want [6] = '{32'h0, 32'h00BB_00DD, 32'h0, 32'h0, 32'h0, 32'hA800_144D};
    for (int i = 0; i < 6; i++) begin
      sb.push_back(exp_t'{want[i], 1'b0});
      apb_xfer(wr[i], 3'd0, off[i], wd[i], st[i], rd, er, cyc);
      e = sb.pop_front();
      vectors++;
      if (rd !== e.data || er !== e.err || cyc !== LAT) begin
        miscompares++;
        $display("FAIL scratch[%0d]: got %h/%b in %0d cycles, want %h/%b in %0d",
                 i, rd, er, cyc, e.data, e.err, LAT);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int cyc; exp_t e;
    logic        wr   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  fn   [7] = '{3'd3, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0};
    logic [11:0] off  [7] = '{12'h000, 12'h044, 12'h002, 12'h040, 12'h042, 12'h040, 12'h004};
    logic        werr [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] want [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00BB_00DD, 32'h0000_0006};
    for (int i = 0; i < 7; i++) begin
      sb.push_back(exp_t'{want[i], werr[i]});
      apb_xfer(wr[i], fn[i], off[i], 32'h1234_5678, 4'hF, rd, er, cyc);
      e = sb.pop_front();
      vectors++;
      if (rd !== e.data || er !== e.err) begin
        miscompares++;
        $display("FAIL err[%0d]: got %h/%b, want %h/%b", i, rd, er, e.data, e.err);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int cyc; exp_t e;
    logic        wr   [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  fn   [11] = '{3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd1};
    logic [11:0] off  [11] = '{12'h040, 12'h03C, 12'h040, 12'h03C, 12'h00C, 12'h00C,
                               12'h004, 12'h004, 12'h030, 12'h030, 12'h02C};
    logic [31:0] wd   [11] = '{32'h1111_1111, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0,
                               32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    logic [3:0]  st   [11] = '{4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'b1000, 4'h0, 4'h0};
    logic [31:0] want [11] = '{32'h0, 32'h0, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0, 32'h0080_FFFF,
                               32'h0, 32'h0000_0407, 32'h0, 32'hFF00_0000, 32'h0};
    for (int i = 0; i < 11; i++) begin
      sb.push_back(exp_t'{want[i], 1'b0});
      apb_xfer(wr[i], fn[i], off[i], wd[i], st[i], rd, er, cyc);
      e = sb.pop_front();
      vectors++;
      if (rd !== e.data || er !== e.err || cyc !== LAT) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got %h/%b in %0d cycles, want %h/%b in %0d",
                 i, rd, er, cyc, e.data, e.err, LAT);
      end
    end
    vectors++;
    if (mem_en !== 2'b11 || bus_master !== 2'b11) begin
      miscompares++;
      $display("FAIL b2b_outputs: got mem=%b bm=%b, want 11/11", mem_en, bus_master);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int cyc; exp_t e;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = {3'd1, 12'h028 + 12'h018}; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
    @(negedge clk); penable = 1'b1;  // SETUP
    @(negedge clk);                  // WAIT
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (pready !== 1'b0 || mem_en !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_mid: got rdy=%b mem=%b, want 0/00", pready, mem_en);
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (pready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_idle: got rdy=%b, want 0", pready);
    end
    sb.push_back(exp_t'{32'h0, 1'b0});
    apb_xfer(1'b0, 3'd1, 12'h040, 32'h0, 4'h0, rd, er, cyc);
    e = sb.pop_front();
    vectors++;
    if (rd !== e.data || er !== e.err) begin
      miscompares++;
      $display("FAIL rst_mid_reg: got %h/%b, want %h/%b", rd, er, e.data, e.err);
    end
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; func_err = '0;
    test_reset();
    test_command();
    test_bar();
    test_status();
    test_scratch_timing();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pcie_cfg_space.md
PCIE_CFG_SPACE -- requirements
Module: pcie_cfg_space

Interface
REQ-001 SHALL have parameter NUM_FUNC, default 2: number of PCIe functions, legal range 1..8.
REQ-002 SHALL have parameter NUM_BAR, default 2: implemented 32-bit memory BARs per function, legal range 1..6.
REQ-003 SHALL have parameter BAR_APERTURE_LOG2, default 12: log2 of each BAR's byte size, legal range 4..31.
REQ-004 SHALL have parameter WAIT_STATES, default 1: APB wait states per access, legal range 0..3.
REQ-005 SHALL have parameters VENDOR_ID (16'h144D), DEVICE_ID (16'hA800), CLASS_CODE (24'h010802) and REV_ID (8'h01): read-only identity fields shared by all functions.
REQ-006 SHALL have port: clk  in  1  clock; all logic on rising edge.
REQ-007 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-008 SHALL have ports: psel_i in 1; penable_i in 1; pwrite_i in 1; standard APB controls.
REQ-009 SHALL have port: paddr_i  in  15  bits [14:12] are the function number, bits [11:0] are the byte offset.
REQ-010 SHALL have ports: pwdata_i in 32; pstrb_i in 4 byte write enables.
REQ-011 SHALL have ports: pready_o out 1; prdata_o out 32; pslverr_o out 1.
REQ-012 SHALL have port: func_err_i  in  NUM_FUNC  per-function error event, one-cycle pulse.
REQ-013 SHALL have ports: mem_en_o out NUM_FUNC (command bit 1); bus_master_o out NUM_FUNC (command bit 2).

Function
REQ-014 SHALL implement an APB FSM with states IDLE, SETUP, WAIT and ACCESS.
REQ-015 FSM transitions SHALL be: IDLE->SETUP on psel_i & !penable_i; SETUP->WAIT when WAIT_STATES>0, else SETUP->ACCESS; WAIT->ACCESS after WAIT_STATES cycles; ACCESS->IDLE.
REQ-016 pready_o SHALL be 1 only in ACCESS, so an access completes in exactly 2+WAIT_STATES cycles from psel_i rising.
REQ-017 Address, write data, strobes and pwrite SHALL be latched in SETUP; bus changes after SETUP SHALL be ignored.
REQ-018 prdata_o SHALL carry read data only while pready_o=1 with a read; otherwise it SHALL be 32'h0.
REQ-019 Writes SHALL commit on the ACCESS cycle only, byte lane k only when pstrb_i[k]=1.
REQ-020 The access SHALL be an error when function >= NUM_FUNC, offset > 0x40, or offset[1:0] != 0.
REQ-021 On an error access: pslverr_o=1 during ACCESS, no register changes, and prdata_o=0.
REQ-022 The register map per function SHALL be: 0x00 {DEVICE_ID,VENDOR_ID}; 0x04 {status,command}; 0x08 {CLASS_CODE,REV_ID}; 0x0C {bist=0, header_type, latency_timer, cache_line_size}; 0x10-0x24 BAR0-5; 0x2C subsystem ids; 0x30 exp_rom_base; 0x3C {max_lat, max_gnt, int_pin, int_line}; 0x40 scratch.
REQ-023 Identity fields, bist and unimplemented offsets (0x28, 0x34, 0x38) SHALL ignore writes; unimplemented offsets SHALL read 0 without error.
REQ-024 header_type SHALL read 8'h80 when NUM_FUNC>1, else 8'h00, and SHALL be read-only.
REQ-025 command SHALL implement only bits [2:0] and bit 10 as RW; all other command bits SHALL read 0.
REQ-026 status bit 11 SHALL be RW1C and SHALL be set by func_err_i[f]; when set and clear occur in the same cycle, set SHALL win; all other status bits SHALL read 0.
REQ-027 BARn with n < NUM_BAR SHALL hold only bits [31:BAR_APERTURE_LOG2]; lower bits SHALL read 0.
REQ-028 Writing 32'hFFFF_FFFF to an implemented BAR SHALL therefore read back ~(2^BAR_APERTURE_LOG2 - 1).
REQ-029 BARs with n >= NUM_BAR SHALL read 0 and ignore writes.
REQ-030 mem_en_o[f] and bus_master_o[f] SHALL be direct register outputs of command bits 1 and 2, and SHALL update the cycle after the write commits.
REQ-031 Back-to-back transfers SHALL be accepted, with SETUP possible on the cycle immediately following ACCESS.

Reset
REQ-032 On rst_n=0 the FSM SHALL return to IDLE, even mid-transfer; the in-flight write SHALL be discarded.
REQ-033 Reset values SHALL be: pready_o=0, pslverr_o=0, prdata_o=0, mem_en_o=0, bus_master_o=0, and every writable field and status bit = 0.

Structure
REQ-034 A shared package pcie_cfg_pkg SHALL hold the FSM state enum, the register offset constants, and the command/status bit index constants.
REQ-035 A single sub-module pcie_cfg_func SHALL hold one function's registers, BAR masking and W1C logic, and SHALL be instantiated NUM_FUNC times via generate.
REQ-036 The top level SHALL hold the APB FSM, address decode, error check and read mux.

Verification
REQ-037 Bench SHALL cover: write 0x0000_0006 to f0 0x04 with pstrb=4'hF -> after ACCESS, mem_en_o[0]=1 and bus_master_o[0]=1; read returns 0x0000_0006.
REQ-038 Bench SHALL cover: write 0xFFFF_FFFF to f1 0x10 with BAR_APERTURE_LOG2=12 -> read returns 0xFFFF_F000; f1 0x18 with NUM_BAR=2 reads 0.
REQ-039 Bench SHALL cover: pulse func_err_i[0], then write status bit 11 = 1 with a simultaneous func_err_i[0] pulse -> bit stays 1; a later W1C with no pulse -> bit reads 0.
REQ-040 Bench SHALL cover: read f3 (NUM_FUNC=2), offset 0x44, and offset 0x02 -> pslverr_o=1 and prdata_o=0 each time, with no register change.
REQ-041 Bench SHALL cover: write 0xAABBCCDD to 0x40 with pstrb=4'b0101 over prior value 0 -> reads 0x00BB00DD; with WAIT_STATES=3, pready_o rises exactly 5 cycles after psel_i.
REQ-042 Bench SHALL cover: assert rst_n=0 during the WAIT state of a write -> pready_o=0 next cycle and the target register is still 0 after reset.
